// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/interlock controller for the multiply-divide unit.
//   It turns E-stage MD instructions into an MDU start pulse and op code, or into
//   a HI/LO write strobe. It counts mult/div latency and drives the D-stage stall.
//   It also flags an MD op that reaches E while the MDU is still busy (overlap).
// Ports:
//   clk, reset (synchronous, active-high)
//   e_valid, e_op[2:0]  - MD instruction in E (0 mult .. 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo)
//   d_is_md             - D-stage instruction is an MD op
//   md_start, md_op, md_we - combinational issue signals to the MDU
//   busy, stall_d       - result pending / freeze F-D and bubble E
//   err_ovl             - sticky overlap error
// Optional feature macro MDU_FLUSH_EN adds:
//   flush    (in)  - exception/eret flush of E
//   md_abort (out) - a flush killed an in-flight mult/div
// Without the macro, a started mult/div always runs to completion.
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [2:0] e_op,
  input  logic       d_is_md,
`ifdef MDU_FLUSH_EN
  input  logic       flush,
  output logic       md_abort,
`endif
  output logic       md_start,
  output logic [2:0] md_op,
  output logic       md_we,
  output logic       busy,
  output logic       stall_d,
  output logic       err_ovl
);

  // The latency counter must be able to hold both latencies, and a zero
  // latency has no meaning.
  if (MULT_LAT <= 0 || DIV_LAT <= 0 ||
      MULT_LAT >= (1 << CNT_W) || DIV_LAT >= (1 << CNT_W)) begin : g_bad_lat
    $error("mdu_issue_ctrl: MULT_LAT/DIV_LAT must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MFHI = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_q, err_nxt;
  logic             flush_e;

`ifdef MDU_FLUSH_EN
  assign flush_e = flush;
`else
  assign flush_e = 1'b0;
`endif

  assign err_ovl = err_q;

  // State register. A reset in the middle of BUSY drops the pending
  // operation: the bench and the pipeline never see it complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state and issue logic. All combinational outputs are held low
  // while reset is asserted, including md_op.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    md_start  = 1'b0;
    md_op     = 3'd0;
    md_we     = 1'b0;
    busy      = 1'b0;
    stall_d   = 1'b0;
`ifdef MDU_FLUSH_EN
    md_abort  = 1'b0;
`endif

    if (!reset) begin
      // With no E op, present mfhi: it has no side effects in the MDU.
      md_op = e_valid ? e_op : OP_MFHI;

      case (state)
        IDLE: begin
          // A flushed E op must not touch the MDU.
          if (e_valid && !flush_e) begin
            if (!e_op[2]) begin
              // mult/multu/div/divu: e_op[1] selects the divide family.
              md_start  = 1'b1;
              state_nxt = BUSY;
              cnt_nxt   = e_op[1] ? DIV_CNT : MULT_CNT;
            end else if (e_op[1]) begin
              // mthi/mtlo write HI/LO directly. mfhi/mflo only read the result.
              md_we = 1'b1;
            end
          end
        end

        BUSY: begin
          if (flush_e) begin
            // The flush wins over everything else this cycle, including
            // an overlapping E op, so err_ovl is left alone.
            state_nxt = IDLE;
            cnt_nxt   = '0;
`ifdef MDU_FLUSH_EN
            md_abort  = 1'b1;
`endif
          end else begin
            // An MD op in E while busy means the stall was ignored upstream.
            // Drop it (no start, no write) and record the violation.
            if (e_valid) begin
              err_nxt = 1'b1;
            end
            if (cnt == CNT_ONE) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CNT_ONE;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase

      // The start cycle itself counts as busy, so an MD op already in D
      // stalls behind a mult/div issued this cycle.
      busy    = (state == BUSY) | md_start;
      stall_d = d_is_md & busy;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       e_valid;
  logic [2:0] e_op;
  logic       d_is_md;
  logic       md_start;
  logic [2:0] md_op;
  logic       md_we;
  logic       busy;
  logic       stall_d;
  logic       err_ovl;
`ifdef MDU_FLUSH_EN
  logic       flush;
  logic       md_abort;
`endif

  mdu_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_op     (e_op),
    .d_is_md  (d_is_md),
`ifdef MDU_FLUSH_EN
    .flush    (flush),
    .md_abort (md_abort),
`endif
    .md_start (md_start),
    .md_op    (md_op),
    .md_we    (md_we),
    .busy     (busy),
    .stall_d  (stall_d),
    .err_ovl  (err_ovl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: rem is the number of busy cycles still owed after the
  // start cycle (0 = MDU free); err_m is the sticky overlap flag.
  int   rem = 0, rem_n = 0;
  bit   err_m = 0, err_n = 0;
  logic       exp_start, exp_we, exp_busy, exp_stall, exp_err, exp_abort;
  logic [2:0] exp_op;

  // Drive one cycle of inputs after the falling edge, then compute what the
  // outputs must be for that cycle and what the model looks like next cycle.
  task automatic apply(input logic rst, input logic v, input logic [2:0] op,
                       input logic dmd, input logic fl);
    bit pend;
    bit eff_fl;
    bit issue;
    @(negedge clk);
    rem   = rem_n;
    err_m = err_n;
    reset   = rst;
    e_valid = v;
    e_op    = op;
    d_is_md = dmd;
`ifdef MDU_FLUSH_EN
    flush  = fl;
    eff_fl = fl;
`else
    eff_fl = 1'b0;
`endif
    #1;
    pend      = (rem > 0);
    exp_err   = err_m;
    exp_start = 0; exp_we = 0; exp_busy = 0; exp_stall = 0; exp_abort = 0;
    exp_op    = 3'd0;
    if (rst) begin
      rem_n = 0;
      err_n = 0;
    end else begin
      exp_op    = v ? op : 3'd4;
      issue     = v && !pend && !eff_fl;
      exp_start = issue && (op <= 3);
      exp_we    = issue && (op >= 6);
      exp_busy  = pend || exp_start;
      exp_stall = dmd && exp_busy;
      exp_abort = eff_fl && pend;
      err_n     = err_m || (v && pend && !eff_fl);
      if (eff_fl && pend)  rem_n = 0;
      else if (exp_start)  rem_n = (op <= 1) ? MULT_LAT : DIV_LAT;
      else if (pend)       rem_n = rem - 1;
      else                 rem_n = 0;
    end
  endtask

  task automatic test_reset();
    apply(1, 0, 3'd0, 0, 0);
    apply(1, 1, 3'd2, 1, 0);
    total++;
    if ({md_start, md_op, md_we, busy, stall_d} !== 7'b0) begin
      bad++;
      $display("FAIL reset_comb got=%b want=0000000", {md_start, md_op, md_we, busy, stall_d});
    end
    apply(0, 0, 3'd0, 1, 0);
    total++;
    if ({err_ovl, busy, stall_d, md_op} !== {3'b000, 3'd4}) begin
      bad++;
      $display("FAIL reset_idle got=%b want=000100", {err_ovl, busy, stall_d, md_op});
    end
    total++;
    if (dut.cnt !== 5'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", dut.cnt);
    end
  endtask

  task automatic test_mult();
    apply(0, 1, 3'd0, 0, 0);
    total++;
    if ({md_start, busy, stall_d} !== 3'b110 ||
        {md_start, md_op, md_we, busy, stall_d, err_ovl} !==
        {exp_start, exp_op, exp_we, exp_busy, exp_stall, exp_err}) begin
      bad++;
      $display("FAIL mult_t0 got=%b%b%b want=110", md_start, busy, stall_d);
    end
    for (int t = 1; t <= 5; t++) begin
      apply(0, 0, 3'd0, 1, 0);
      total++;
      if ({md_start, busy, stall_d} !== 3'b011 || busy !== exp_busy) begin
        bad++;
        $display("FAIL mult_t%0d got=%b%b%b want=011", t, md_start, busy, stall_d);
      end
    end
    apply(0, 0, 3'd0, 1, 0);
    total++;
    if ({busy, stall_d} !== 2'b00) begin
      bad++;
      $display("FAIL mult_t6 got=%b%b want=00", busy, stall_d);
    end
  endtask

  task automatic test_divu();
    apply(0, 1, 3'd3, 0, 0);
    total++;
    if (md_op !== 3'd3 || md_start !== 1'b1) begin
      bad++;
      $display("FAIL divu_t0 got op=%0d start=%b want op=3 start=1", md_op, md_start);
    end
    for (int t = 1; t <= 10; t++) begin
      apply(0, 0, 3'd0, 0, 0);
      total++;
      if (dut.cnt !== 5'(11 - t) || busy !== 1'b1) begin
        bad++;
        $display("FAIL divu_t%0d got cnt=%0d busy=%b want cnt=%0d busy=1", t, dut.cnt, busy, 11 - t);
      end
    end
    apply(0, 0, 3'd0, 1, 0);
    total++;
    if (busy !== 1'b0 || stall_d !== 1'b0 || dut.cnt !== 5'd0) begin
      bad++;
      $display("FAIL divu_t11 got busy=%b stall=%b cnt=%0d want 0 0 0", busy, stall_d, dut.cnt);
    end
  endtask

  task automatic test_mthi();
    apply(0, 1, 3'd6, 1, 0);
    total++;
    if ({md_we, md_start, busy, stall_d} !== 4'b1000) begin
      bad++;
      $display("FAIL mthi got=%b want=1000", {md_we, md_start, busy, stall_d});
    end
    apply(0, 0, 3'd0, 1, 0);
    total++;
    if ({md_we, md_start, busy} !== 3'b000) begin
      bad++;
      $display("FAIL mthi_after got=%b want=000", {md_we, md_start, busy});
    end
  endtask

  task automatic test_overlap();
    apply(0, 1, 3'd2, 0, 0);
    apply(0, 0, 3'd0, 0, 0);
    apply(0, 1, 3'd0, 0, 0);
    total++;
    if (md_start !== 1'b0 || md_we !== 1'b0 || dut.cnt !== 5'd9) begin
      bad++;
      $display("FAIL ovl_t2 got start=%b we=%b cnt=%0d want 0 0 9", md_start, md_we, dut.cnt);
    end
    for (int t = 3; t <= 20; t++) begin
      apply(0, 0, 3'd0, 0, 0);
      total++;
      if (err_ovl !== 1'b1 || dut.cnt !== 5'(rem) || busy !== exp_busy) begin
        bad++;
        $display("FAIL ovl_t%0d got err=%b cnt=%0d busy=%b want err=1 cnt=%0d busy=%b",
                 t, err_ovl, dut.cnt, busy, rem, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 1, 3'd1, 0, 0);
    apply(0, 0, 3'd0, 0, 0);
    apply(0, 0, 3'd0, 0, 0);
    apply(1, 0, 3'd0, 1, 0);
    total++;
    if ({busy, stall_d} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_t3 got busy=%b stall=%b want 0 0", busy, stall_d);
    end
    apply(0, 0, 3'd0, 1, 0);
    total++;
    if (busy !== 1'b0 || stall_d !== 1'b0 || dut.cnt !== 5'd0 || err_ovl !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_t4 got busy=%b stall=%b cnt=%0d err=%b want 0 0 0 0",
               busy, stall_d, dut.cnt, err_ovl);
    end
  endtask

`ifdef MDU_FLUSH_EN
  task automatic test_flush();
    apply(0, 1, 3'd2, 0, 0);
    for (int t = 1; t <= 3; t++) apply(0, 0, 3'd0, 0, 0);
    apply(0, 1, 3'd0, 0, 1);
    total++;
    if (md_abort !== 1'b1 || md_start !== 1'b0) begin
      bad++;
      $display("FAIL flush_t4 got abort=%b start=%b want 1 0", md_abort, md_start);
    end
    apply(0, 0, 3'd0, 0, 0);
    total++;
    if (busy !== 1'b0 || err_ovl !== 1'b0) begin
      bad++;
      $display("FAIL flush_t5 got busy=%b err=%b want 0 0", busy, err_ovl);
    end
    apply(0, 1, 3'd1, 1, 1);
    total++;
    if (md_start !== 1'b0 || busy !== 1'b0 || md_abort !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle got start=%b busy=%b abort=%b want 0 0 0", md_start, busy, md_abort);
    end
  endtask
`endif

  task automatic test_random();
    logic rst, v, dmd, fl;
    logic [2:0] op;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(63) == 0);
      v   = ($urandom_range(2) != 0);
      op  = 3'($urandom_range(7));
      dmd = 1'($urandom_range(1));
      fl  = ($urandom_range(15) == 0);
      apply(rst, v, op, dmd, fl);
      total++;
      if ({md_start, md_op, md_we, busy, stall_d, err_ovl} !==
          {exp_start, exp_op, exp_we, exp_busy, exp_stall, exp_err}) begin
        bad++;
        $display("FAIL rand_%0d outs got=%b want=%b", i,
                 {md_start, md_op, md_we, busy, stall_d, err_ovl},
                 {exp_start, exp_op, exp_we, exp_busy, exp_stall, exp_err});
      end
      total++;
      if (dut.cnt !== 5'(rem)) begin
        bad++;
        $display("FAIL rand_%0d cnt got=%0d want=%0d", i, dut.cnt, rem);
      end
`ifdef MDU_FLUSH_EN
      total++;
      if (md_abort !== exp_abort) begin
        bad++;
        $display("FAIL rand_%0d abort got=%b want=%b", i, md_abort, exp_abort);
      end
`endif
    end
  endtask

  initial begin
    reset   = 1'b1;
    e_valid = 1'b0;
    e_op    = 3'd0;
    d_is_md = 1'b0;
`ifdef MDU_FLUSH_EN
    flush   = 1'b0;
`endif
    test_reset();
    test_mult();
    test_divu();
    test_mthi();
    test_overlap();
    test_reset_mid();
`ifdef MDU_FLUSH_EN
    apply(1, 0, 3'd0, 0, 0);
    test_flush();
`endif
    apply(1, 0, 3'd0, 0, 0);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
